// File: rtl/stream_packet_arbiter.sv
// stream_packet_arbiter: packet-aware round-robin merge of NUM_IN byte streams onto one registered output.
module stream_packet_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_BYTES = 8,
  parameter int CNT_W      = $clog2(DATA_BYTES),
  parameter int SRC_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN-1:0]              en_mask,
  input  logic [NUM_IN*DATA_BYTES*8-1:0] in_data,
  input  logic [NUM_IN*CNT_W-1:0]        in_cnt,
  input  logic [NUM_IN-1:0]              in_last,
  input  logic [NUM_IN-1:0]              in_valid,
  output logic [NUM_IN-1:0]              in_ready,
  output logic [DATA_BYTES*8-1:0]        out_data,
  output logic [CNT_W-1:0]               out_cnt,
  output logic                           out_last,
  output logic [SRC_W-1:0]               out_src,
  output logic                           out_valid,
  input  logic                           out_ready
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]        r_state;
  logic [SRC_W-1:0]  r_grant;
  logic [SRC_W-1:0]  r_rr;
  logic [SRC_W-1:0]  w_win;
  logic [SRC_W-1:0]  w_next;
  logic [NUM_IN-1:0] w_cand;
  logic              w_free;
  logic              w_xfer;
  assign w_cand   = in_valid & en_mask;
  assign w_free   = !out_valid || out_ready;
  assign w_xfer   = (r_state == BUSY) && w_free && in_valid[r_grant];
  assign in_ready = (r_state == BUSY && w_free) ? NUM_IN'(1) << r_grant : '0;
  assign w_next   = (int'(r_grant) == NUM_IN - 1) ? '0 : r_grant + 1'b1;
  // Scan from the farthest offset down so the candidate nearest r_rr wins.
  always_comb begin
    w_win = r_rr;
    for (int k = NUM_IN - 1; k >= 0; k--)
      if (w_cand[(int'(r_rr) + k) % NUM_IN]) w_win = SRC_W'((int'(r_rr) + k) % NUM_IN);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      if (r_state == IDLE && |w_cand) begin
        r_grant <= w_win;
        r_state <= BUSY;
      end
      if (w_xfer) begin
        out_data  <= in_data[int'(r_grant)*DATA_BYTES*8 +: DATA_BYTES*8];
        out_cnt   <= in_cnt[int'(r_grant)*CNT_W +: CNT_W];
        out_last  <= in_last[r_grant];
        out_src   <= r_grant;
        out_valid <= 1'b1;
        if (in_last[r_grant]) begin
          r_state <= IDLE;
          r_rr    <= w_next;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_packet_arbiter.sv
// tb_stream_packet_arbiter: randomized and directed stimulus against a transaction-level arbiter model.
module tb_stream_packet_arbiter;
  localparam int N = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  en_mask = '1;
  logic [N*64-1:0] in_data = '0;
  logic [N*3-1:0]  in_cnt = '0;
  logic [N-1:0]  in_last = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [63:0]   out_data;
  logic [2:0]    out_cnt;
  logic          out_last;
  logic [1:0]    out_src;
  logic          out_valid;
  logic          out_ready = 1'b1;

  stream_packet_arbiter #(.NUM_IN(N), .DATA_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .en_mask(en_mask), .in_data(in_data), .in_cnt(in_cnt),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_last(out_last), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic [2:0] c; logic l; } beat_t;
  typedef struct { logic [63:0] d; logic [2:0] c; logic l; int s; } obeat_t;
  beat_t  q[N][$];
  obeat_t slot[$];
  int owner = -1;
  int ptr = 0;
  int p_off = 100;
  int p_rdy = 100;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_beat(input int i, input logic [63:0] d, input logic [2:0] c, input logic l);
    q[i].push_back('{d, c, l});
  endtask

  task automatic add_pkt(input int i, input int n);
    for (int b = 0; b < n; b++) add_beat(i, {$urandom, $urandom}, 3'($urandom_range(7)), b == n - 1);
  endtask

  // One clock: drive, check in_ready, advance the model, check the output register.
  task automatic cycle();
    logic [N-1:0] iv;
    logic [N-1:0] exp_rdy;
    bit free;
    bit xf;
    bit found;
    beat_t b;
    for (int i = 0; i < N; i++) begin
      iv[i] = q[i].size() > 0 && $urandom_range(99) < p_off;
      in_valid[i] = iv[i];
      in_data[i*64 +: 64] = q[i].size() > 0 ? q[i][0].d : 64'h0;
      in_cnt[i*3 +: 3] = q[i].size() > 0 ? q[i][0].c : 3'h0;
      in_last[i] = q[i].size() > 0 ? q[i][0].l : 1'b0;
    end
    out_ready = $urandom_range(99) < p_rdy;
    #1;
    free = slot.size() == 0 || out_ready;
    exp_rdy = (owner >= 0 && free) ? N'(1) << owner : '0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (!rst_n) begin
      owner = -1;
      ptr = 0;
      slot.delete();
    end else begin
      xf = owner >= 0 && free && iv[owner];
      if (slot.size() > 0 && out_ready) void'(slot.pop_front());
      if (owner < 0) begin
        found = 0;
        for (int k = 0; k < N; k++)
          if (!found && iv[(ptr + k) % N] && en_mask[(ptr + k) % N]) begin
            owner = (ptr + k) % N;
            found = 1;
          end
      end else if (xf) begin
        b = q[owner].pop_front();
        slot.push_back('{b.d, b.c, b.l, owner});
        if (b.l) begin
          ptr = (owner + 1) % N;
          owner = -1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(slot.size() > 0));
    if (slot.size() > 0) begin
      check("out_data", out_data, slot[0].d);
      check("out_cnt", 64'(out_cnt), 64'(slot[0].c));
      check("out_last", 64'(out_last), 64'(slot[0].l));
      check("out_src", 64'(out_src), 64'(slot[0].s));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    run(2);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h0);
    check("rst_src", 64'(out_src), 64'h0);
    check("rst_data", out_data, 64'h0);
    rst_n = 1'b1;
    add_beat(0, 64'hA0, 3'd7, 1'b0);
    add_beat(0, 64'hA1, 3'd3, 1'b1);
    add_beat(2, 64'hB0, 3'd7, 1'b0);
    add_beat(2, 64'hB1, 3'd0, 1'b1);
    run(8);
    for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) add_pkt(i, 1);
    run(30);
    add_pkt(1, 6);
    run(3);
    p_rdy = 0;
    run(5);
    p_rdy = 100;
    run(8);
    en_mask = 4'b1011;
    add_pkt(2, 2);
    run(10);
    en_mask = 4'hF;
    run(6);
    add_pkt(1, 3);
    add_pkt(3, 2);
    for (int c = 0; c < 20 && q[1].size() > 2; c++) cycle();
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    q[1].delete();
    run(10);
    p_off = 70;
    p_rdy = 60;
    for (int c = 0; c < 2000; c++) begin
      if (c % 50 == 0) en_mask = 4'($urandom_range(15));
      for (int i = 0; i < N; i++) if (q[i].size() < 4 && $urandom_range(9) == 0) add_pkt(i, $urandom_range(1, 4));
      cycle();
    end
    en_mask = 4'hF;
    p_off = 100;
    p_rdy = 100;
    run(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
